keypad_matrix_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_row_driver.sv | 39 +++
 rtl/keypad_matrix_scanner.sv | 129 ++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key-index helpers for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned N_ROWS     = 4;
   localparam int unsigned N_COLS     = 4;
   localparam int unsigned N_KEYS     = N_ROWS * N_COLS;
   localparam int unsigned ROW_W      = 2;
   localparam int unsigned COL_W      = 2;
   localparam int unsigned KEY_CODE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_t;

   // Key code / bit position of a matrix key: {row, col}.
   function automatic logic [KEY_CODE_W-1:0] key_index(input logic [ROW_W-1:0] row,
                                                        input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

   // Priority encoder: index of the lowest set bit, 0 when none is set.
   function automatic logic [KEY_CODE_W-1:0] lowest_set16(input logic [N_KEYS-1:0] v);
      logic [KEY_CODE_W-1:0] idx;
      idx = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = KEY_CODE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Row scan timing: dwell counter, row index, one-cold row drive and sample/frame-end strobes.
module keypad_row_driver
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 25000
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ROW_W-1:0]  row_idx,
   output logic [N_ROWS-1:0] keyboard_row,
   output logic              sample_c,
   output logic              frame_end_c
);

   localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DWELL_W-1:0] dwell;
   logic [ROW_W-1:0]   next_idx;

   // Columns are captured on the last dwell cycle, well after the row change has settled.
   assign sample_c    = (dwell == DWELL_W'(SCAN_DIV - 1));
   assign frame_end_c = sample_c && (row_idx == ROW_W'(N_ROWS - 1));
   assign next_idx    = row_idx + ROW_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell        <= '0;
         row_idx      <= '0;
         keyboard_row <= 4'b1110;
      end else if (sample_c) begin
         dwell        <= '0;
         row_idx      <= next_idx;
         keyboard_row <= ~(4'b0001 << next_idx);
      end else begin
         dwell        <= dwell + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad reader: scans rows, debounces full-matrix frames, emits press/release events.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 25000,
   parameter int unsigned DEBOUNCE_FRAMES = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [N_ROWS-1:0]     keyboard_row,
   input  logic [N_COLS-1:0]     keyboard_col,
   output logic                  key_valid,
   output logic                  key_released,
   output logic [KEY_CODE_W-1:0] key_code,
   output logic [N_KEYS-1:0]     key_state
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

   logic [ROW_W-1:0]      row_idx;
   logic                  sample_c;
   logic                  frame_end_c;

   logic [N_COLS-1:0]     col_meta;
   logic [N_COLS-1:0]     col_sync;
   logic [N_KEYS-1:0]     raw_frame;
   logic [N_KEYS-1:0]     prev_frame;
   logic [N_KEYS-1:0]     old_state;
   logic [N_KEYS-1:0]     frame_next_c;
   logic [N_KEYS-1:0]     new_press_c;
   logic [CNT_W-1:0]      db_cnt;
   logic [CNT_W-1:0]      db_cnt_next_c;
   logic                  accept_c;
   logic                  eval;
   state_t                state;
   logic [KEY_CODE_W-1:0] tracked;

   keypad_row_driver #(
      .SCAN_DIV (SCAN_DIV)
   ) u_row_driver (
      .clk          (clk),
      .rst          (rst),
      .row_idx      (row_idx),
      .keyboard_row (keyboard_row),
      .sample_c     (sample_c),
      .frame_end_c  (frame_end_c)
   );

   // Frame as it will look once the current row's columns are merged in (pressed = 1).
   always_comb begin
      frame_next_c = raw_frame;
      frame_next_c[key_index(row_idx, COL_W'(0)) +: N_COLS] = ~col_sync;
   end

   always_comb begin
      db_cnt_next_c = CNT_W'(1);
      if (frame_next_c == prev_frame) begin
         if (db_cnt >= CNT_W'(DEBOUNCE_FRAMES)) db_cnt_next_c = CNT_W'(DEBOUNCE_FRAMES);
         else                                   db_cnt_next_c = db_cnt + CNT_W'(1);
      end
   end

   assign accept_c    = frame_end_c && (db_cnt_next_c == CNT_W'(DEBOUNCE_FRAMES))
                        && (frame_next_c != key_state);
   assign new_press_c = key_state & ~old_state;

   // Synchronizer, frame capture and debounce of whole-matrix snapshots.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta   <= '1;
         col_sync   <= '1;
         raw_frame  <= '0;
         prev_frame <= '0;
         db_cnt     <= '0;
         key_state  <= '0;
         old_state  <= '0;
         eval       <= 1'b0;
      end else begin
         col_meta <= keyboard_col;
         col_sync <= col_meta;
         eval     <= 1'b0;
         if (sample_c) raw_frame <= frame_next_c;
         if (frame_end_c) begin
            db_cnt <= db_cnt_next_c;
            if (frame_next_c != prev_frame) prev_frame <= frame_next_c;
         end
         if (accept_c) begin
            key_state <= frame_next_c;
            old_state <= key_state;
            eval      <= 1'b1;
         end
      end
   end

   // Event FSM: tracks a single key; extra keys only show up in key_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tracked      <= '0;
         key_valid    <= 1'b0;
         key_released <= 1'b0;
         key_code     <= '0;
      end else begin
         key_valid    <= 1'b0;
         key_released <= 1'b0;
         if (eval) begin
            case (state)
               IDLE: begin
                  if (|new_press_c) begin
                     tracked   <= lowest_set16(new_press_c);
                     key_code  <= lowest_set16(new_press_c);
                     key_valid <= 1'b1;
                     state     <= HELD;
                  end
               end
               HELD: begin
                  if (!key_state[tracked]) begin
                     key_code     <= tracked;
                     key_released <= 1'b1;
                     state        <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner with a behavioural 4x4 key matrix.
module tb_keypad_matrix_scanner;

   typedef struct packed {
      logic        rel;
      logic [3:0]  code;
      logic [15:0] state;
   } ev_t;

   logic        clk;
   logic        rst;
   logic [3:0]  keyboard_row;
   logic [3:0]  keyboard_col;
   logic        key_valid;
   logic        key_released;
   logic [3:0]  key_code;
   logic [15:0] key_state;

   logic [15:0] pressed;
   logic        rst_d;
   logic [3:0]  last_code;
   ev_t         exp_q[$];
   int          n_checks;
   int          n_fail;

   keypad_matrix_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_FRAMES (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .keyboard_row (keyboard_row),
      .keyboard_col (keyboard_col),
      .key_valid    (key_valid),
      .key_released (key_released),
      .key_code     (key_code),
      .key_state    (key_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix model: a column reads low when its key sits on the driven (low) row.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         keyboard_col[c] = 1'b1;
         for (int r = 0; r < 4; r++)
            if (!keyboard_row[r] && pressed[r*4+c]) keyboard_col[c] = 1'b0;
      end
   end

   always @(posedge clk) rst_d <= rst;

   // Monitor: every event pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      ev_t e;
      if (!rst && !rst_d) begin
         if (key_valid || key_released) begin
            n_checks++;
            if (key_valid && key_released) begin
               n_fail++;
               $display("FAIL both_pulses: valid=%0b released=%0b, required one at a time", key_valid, key_released);
            end else if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: valid=%0b released=%0b code=%0d state=%04h, required no event",
                        key_valid, key_released, key_code, key_state);
            end else begin
               e = exp_q.pop_front();
               if (e.rel !== key_released || e.code !== key_code || e.state !== key_state) begin
                  n_fail++;
                  $display("FAIL event: released=%0b code=%0d state=%04h, required released=%0b code=%0d state=%04h",
                           key_released, key_code, key_state, e.rel, e.code, e.state);
               end
            end
         end else if (key_code !== last_code) begin
            n_checks++;
            n_fail++;
            $display("FAIL code_hold: key_code changed %0d -> %0d without a pulse", last_code, key_code);
         end
      end
      last_code = key_code;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_ev(input logic rel, input logic [3:0] code, input logic [15:0] st);
      ev_t e;
      e.rel   = rel;
      e.code  = code;
      e.state = st;
      exp_q.push_back(e);
   endtask

   // Wait until the monitor consumed every expected event, bounded by a cycle budget.
   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d event(s) outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   // Return just after row 0 becomes active (start of a frame).
   task automatic align_frame();
      int k;
      k = 0;
      while (keyboard_row !== 4'b0111 && k < 40) begin @(negedge clk); k++; end
      while (keyboard_row !== 4'b1110 && k < 40) begin @(negedge clk); k++; end
      if (k >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL align_frame: row=%04b, no frame start seen within 40 cycles", keyboard_row);
      end
   endtask

   task automatic frames(input int n);
      repeat (n * 16) @(negedge clk);
   endtask

   initial begin
      logic [3:0] one;
      logic [3:0] exp_row;
      n_checks = 0;
      n_fail   = 0;
      pressed  = 16'h0000;
      rst      = 1'b1;
      one      = 4'b0001;
      repeat (3) @(negedge clk);

      check("reset_row",      32'(keyboard_row), 32'h0000000e);
      check("reset_valid",    32'(key_valid),    32'h0);
      check("reset_released", 32'(key_released), 32'h0);
      check("reset_code",     32'(key_code),     32'h0);
      check("reset_state",    32'(key_state),    32'h0);

      // Idle scan: rows rotate every 4 clocks, no events.
      rst = 1'b0;
      for (int i = 0; i < 160; i++) begin
         exp_row = ~(one << ((i / 4) % 4));
         check("row_scan", 32'(keyboard_row), 32'(exp_row));
         @(negedge clk);
      end
      check("idle_state", 32'(key_state), 32'h0);

      // Single press (1,2) from a frame start.
      align_frame();
      pressed = 16'h0040;
      push_ev(1'b0, 4'd6, 16'h0040);
      drain("press_1_2_latency", 68);
      frames(8);
      check("held_state_1_2", 32'(key_state), 32'h00000040);

      // Release (1,2).
      pressed = 16'h0000;
      push_ev(1'b1, 4'd6, 16'h0000);
      drain("release_1_2", 100);
      check("released_state", 32'(key_state), 32'h0);

      // Bounce: one-frame toggles never reach the debounce threshold.
      align_frame();
      for (int f = 0; f < 8; f++) begin
         pressed = (f % 2 == 0) ? 16'h0040 : 16'h0000;
         frames(1);
      end
      pressed = 16'h0000;
      frames(6);
      check("bounce_state", 32'(key_state), 32'h0);

      // Two keys in one frame: lowest index reported, no rollover events.
      align_frame();
      pressed = 16'h0202;
      push_ev(1'b0, 4'd1, 16'h0202);
      drain("press_pair", 100);
      frames(2);
      check("pair_state", 32'(key_state), 32'h00000202);
      pressed = 16'h0002;
      frames(6);
      check("pair_partial_release", 32'(key_state), 32'h00000002);
      pressed = 16'h0000;
      push_ev(1'b1, 4'd1, 16'h0000);
      drain("release_0_1", 100);

      // Reset while HELD, key still down: clean reset then a fresh press.
      pressed = 16'h8000;
      push_ev(1'b0, 4'd15, 16'h8000);
      drain("press_3_3", 100);
      frames(1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_held_row",      32'(keyboard_row), 32'h0000000e);
      check("rst_held_valid",    32'(key_valid),    32'h0);
      check("rst_held_released", 32'(key_released), 32'h0);
      check("rst_held_code",     32'(key_code),     32'h0);
      check("rst_held_state",    32'(key_state),    32'h0);
      push_ev(1'b0, 4'd15, 16'h8000);
      drain("repress_3_3", 100);
      pressed = 16'h0000;
      push_ev(1'b1, 4'd15, 16'h0000);
      drain("release_3_3", 100);
      frames(4);
      check("final_state", 32'(key_state), 32'h0);
      check("final_queue", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
